// File: rtl/wb_regfile.sv
// Writeback stage and register file.
// Selects the MEM/WB writeback value and commits it to a 2**ADDR_W entry register file.
// Two combinational read ports bypass a same-cycle commit so ID never reads stale data.
// Also counts committed writebacks.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] MEM_WB_MemReadData,
  input  logic [DATA_W-1:0] MEM_WB_ALUResult,
  input  logic [ADDR_W-1:0] MEM_WB_WriteReg,
  input  logic              MEM_WB_RegWrite,
  input  logic              MEM_WB_MemtoReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [CNT_W-1:0]  WB_Count
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [CNT_W-1:0]  count_q;
  logic              commit;

  // Writeback mux and commit qualifier; a RegWrite of 0 gates everything, even with X operands.
  always_comb begin
    WB_WriteData = MEM_WB_MemtoReg ? MEM_WB_MemReadData : MEM_WB_ALUResult;
    commit       = MEM_WB_RegWrite && (MEM_WB_WriteReg != '0);
  end

  for (genvar g = 0; g < NumRegs; g++) begin : gen_regs
    if (g == 0) begin : gen_zero
      // $zero has no storage.
      assign regs_q[g] = '0;
    end else begin : gen_reg
      // One flop row per register, written only when this index is the commit target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[g] <= '0;
        end else if (commit && (MEM_WB_WriteReg == ADDR_W'(g))) begin
          regs_q[g] <= WB_WriteData;
        end
      end
    end
  end

  // Commit counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (commit) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign WB_Count = count_q;

  // Read ports: index 0 is forced to zero, otherwise a same-cycle commit to the index bypasses.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadReg1 != '0) begin
      if (commit && (ReadReg1 == MEM_WB_WriteReg)) begin
        ReadData1 = WB_WriteData;
      end else begin
        ReadData1 = regs_q[ReadReg1];
      end
    end
    if (ReadReg2 != '0) begin
      if (commit && (ReadReg2 == MEM_WB_WriteReg)) begin
        ReadData2 = WB_WriteData;
      end else begin
        ReadData2 = regs_q[ReadReg2];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// A second instance with a 4-bit counter shares the stimulus but is held in reset until the
// counter-wrap sequence.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic [31:0] mem_read_data;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic        mem_to_reg;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] wb_write_data;
  logic [31:0] wb_count;
  logic [31:0] w_read_data1;
  logic [31:0] w_read_data2;
  logic [31:0] w_wb_write_data;
  logic [3:0]  w_wb_count;

  int checks = 0;
  int errors = 0;

  wb_regfile u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .MEM_WB_MemReadData (mem_read_data),
    .MEM_WB_ALUResult   (alu_result),
    .MEM_WB_WriteReg    (write_reg),
    .MEM_WB_RegWrite    (reg_write),
    .MEM_WB_MemtoReg    (mem_to_reg),
    .ReadReg1           (read_reg1),
    .ReadReg2           (read_reg2),
    .ReadData1          (read_data1),
    .ReadData2          (read_data2),
    .WB_WriteData       (wb_write_data),
    .WB_Count           (wb_count)
  );

  wb_regfile #(
    .CNT_W (4)
  ) u_dut_wrap (
    .clk                (clk),
    .rst_n              (rst2_n),
    .MEM_WB_MemReadData (mem_read_data),
    .MEM_WB_ALUResult   (alu_result),
    .MEM_WB_WriteReg    (write_reg),
    .MEM_WB_RegWrite    (reg_write),
    .MEM_WB_MemtoReg    (mem_to_reg),
    .ReadReg1           (read_reg1),
    .ReadReg2           (read_reg2),
    .ReadData1          (w_read_data1),
    .ReadData2          (w_read_data2),
    .WB_WriteData       (w_wb_write_data),
    .WB_Count           (w_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    rst2_n        = 1'b0;
    mem_read_data = '0;
    alu_result    = '0;
    write_reg     = '0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    read_reg1     = '0;
    read_reg2     = '0;

    // Reset: every register and the counter read zero.
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_count", wb_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_r%0d", i), read_data1, 32'd0);
      check($sformatf("reset_rd2_r%0d", 31 - i), read_data2, 32'd0);
    end

    // ALU writeback to r8.
    reg_write     = 1'b1;
    mem_to_reg    = 1'b0;
    alu_result    = 32'h0000_1234;
    mem_read_data = 32'hDEAD_BEEF;
    write_reg     = 5'd8;
    read_reg1     = 5'd1;
    #1;
    check("alu_wbdata", wb_write_data, 32'h0000_1234);
    step();
    reg_write = 1'b0;
    read_reg1 = 5'd8;
    #1;
    check("alu_rd1_r8", read_data1, 32'h0000_1234);
    check("alu_count", wb_count, 32'd1);

    // Load writeback to r9 seen through the bypass on both ports in the same cycle.
    reg_write     = 1'b1;
    mem_to_reg    = 1'b1;
    mem_read_data = 32'hCAFE_F00D;
    write_reg     = 5'd9;
    read_reg1     = 5'd9;
    read_reg2     = 5'd9;
    #1;
    check("byp_rd1", read_data1, 32'hCAFE_F00D);
    check("byp_rd2", read_data2, 32'hCAFE_F00D);
    check("byp_wbdata", wb_write_data, 32'hCAFE_F00D);
    check("byp_count_pre", wb_count, 32'd1);
    // Non-matching port still reads the array.
    read_reg2 = 5'd8;
    #1;
    check("byp_rd2_other", read_data2, 32'h0000_1234);
    read_reg2 = 5'd9;
    step();
    reg_write = 1'b0;
    #1;
    check("load_rd1_r9", read_data1, 32'hCAFE_F00D);
    check("load_rd2_r9", read_data2, 32'hCAFE_F00D);
    check("load_count", wb_count, 32'd2);

    // Writes to $zero are dropped and not counted; bypass never fires for index 0.
    reg_write  = 1'b1;
    mem_to_reg = 1'b0;
    write_reg  = 5'd0;
    alu_result = 32'hFFFF_FFFF;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    #1;
    check("zero_rd1_pre", read_data1, 32'd0);
    check("zero_rd2_pre", read_data2, 32'd0);
    step();
    reg_write = 1'b0;
    #1;
    check("zero_rd1_post", read_data1, 32'd0);
    check("zero_count", wb_count, 32'd2);

    // Disabled write leaves r8 alone.
    reg_write  = 1'b0;
    write_reg  = 5'd8;
    alu_result = 32'h5555_5555;
    read_reg1  = 5'd8;
    read_reg2  = 5'd9;
    #1;
    check("dis_rd1_pre", read_data1, 32'h0000_1234);
    step();
    check("dis_rd1_post", read_data1, 32'h0000_1234);
    check("dis_count", wb_count, 32'd2);

    // Asynchronous reset between edges clears state immediately.
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rd1_r8", read_data1, 32'd0);
    check("arst_rd2_r9", read_data2, 32'd0);
    check("arst_count", wb_count, 32'd0);
    rst_n = 1'b1;
    #1;
    check("arst_rel_count", wb_count, 32'd0);

    // Counter wrap on the 4-bit instance: 17 commits of 1..17 to r3.
    rst2_n     = 1'b1;
    read_reg1  = 5'd3;
    read_reg2  = 5'd3;
    reg_write  = 1'b1;
    mem_to_reg = 1'b0;
    write_reg  = 5'd3;
    for (int v = 1; v <= 17; v++) begin
      alu_result = 32'(v);
      step();
      check($sformatf("wrap_count_%0d", v), {28'd0, w_wb_count}, 32'(v % 16));
    end
    reg_write = 1'b0;
    #1;
    check("wrap_final_count", {28'd0, w_wb_count}, 32'd1);
    check("wrap_rd1_r3", w_read_data1, 32'd17);
    check("wrap_rd2_r3", w_read_data2, 32'd17);
    check("main_count_17", wb_count, 32'd17);
    check("main_rd1_r3", read_data1, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
